// File: rtl/prbs_burst_checker.sv
// prbs_burst_checker: hunts for the burst preamble on the MAC RX stream,
// self-seeds a PRBS-31 reference from the first payload beat, checks the
// remaining beats and accumulates burst/error/truncation statistics.
// Optional feature macro: PRBS_BIT_ERR_CNT_EN builds the per-bit error
// counter. Without it, bit_err_count is tied to 0.
module prbs_burst_checker #(
  parameter logic [31:0] SYNC_WORD   = 32'h05560556,
  parameter int unsigned GAP_TIMEOUT = 64,
  parameter int unsigned LOCK_BURSTS = 4
) (
  input  logic        rx_axis_usrclk,
  input  logic        reset_in,
  input  logic [31:0] rx_axis_tdata,
  input  logic        rx_axis_tvalid,
  input  logic        rx_axis_tlast,
  input  logic        rx_axis_tuser,
  input  logic [31:0] preamble_length,
  input  logic [31:0] burst_length,
  input  logic        link_down_latched_reset_in,
  output logic        burst_done,
  output logic [31:0] burst_count,
  output logic [31:0] err_beat_count,
  output logic [31:0] bit_err_count,
  output logic [31:0] trunc_count,
  output logic [15:0] fcs_err_count,
  output logic        lock,
  output logic        link_down_latched
);

  localparam int unsigned DW = 32;
  localparam int unsigned FW = 16;

  localparam logic [1:0] ST_HUNT  = 2'd0;
  localparam logic [1:0] ST_PRE   = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Next 32 bits of s[n] = s[n-31] ^ s[n-28], oldest bit in the MSB.
  // s[0..31] is the received word; s[32..63] reuse freshly computed bits.
  function automatic logic [DW-1:0] prbs_next(input logic [DW-1:0] w);
    logic [2*DW-1:0] s;
    logic [DW-1:0]   r;
    s = '0;
    for (int unsigned t = 0; t < DW; t++) s[t] = w[DW-1-t];
    for (int unsigned t = DW; t < 2*DW; t++) s[t] = s[t-31] ^ s[t-28];
    for (int unsigned j = 0; j < DW; j++) r[DW-1-j] = s[DW+j];
    return r;
  endfunction

  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] x);
    return (&x) ? x : x + DW'(1);
  endfunction

  function automatic logic [FW-1:0] sat_inc16(input logic [FW-1:0] x);
    return (&x) ? x : x + FW'(1);
  endfunction

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] pcnt_q, pcnt_d;
  logic [DW-1:0] bcnt_q, bcnt_d;
  logic [DW-1:0] gap_q, gap_d;
  logic [DW-1:0] exp_q, exp_d;
  logic          berr_q, berr_d;
  logic [DW-1:0] clean_q, clean_d;
  logic          burst_done_q, burst_done_d;
  logic [DW-1:0] burst_count_q, burst_count_d;
  logic [DW-1:0] err_beat_q, err_beat_d;
  logic [DW-1:0] trunc_q, trunc_d;
  logic [FW-1:0] fcs_q, fcs_d;
  logic          lock_q, lock_d;
  logic          ldl_q, ldl_d;

  logic [DW-1:0] pre_eff_c;
  logic [DW-1:0] burst_eff_c;
  logic          is_sync_c;
  logic [DW-1:0] diff_c;
  logic          mism_c;
  logic          fin_c;
  logic          fin_trunc_c;
  logic          fin_err_c;

  // Zero-length settings behave as one.
  assign pre_eff_c   = (preamble_length == '0) ? DW'(1) : preamble_length;
  assign burst_eff_c = (burst_length == '0) ? DW'(1) : burst_length;
  assign is_sync_c   = (rx_axis_tdata == SYNC_WORD);
  assign diff_c      = rx_axis_tdata ^ exp_q;
  assign mism_c      = (state_q == ST_CHECK) && rx_axis_tvalid && (|diff_c);

  // Next-state and statistics update.
  always_comb begin
    state_d       = state_q;
    pcnt_d        = pcnt_q;
    bcnt_d        = bcnt_q;
    gap_d         = gap_q;
    exp_d         = exp_q;
    berr_d        = berr_q;
    clean_d       = clean_q;
    burst_done_d  = 1'b0;
    burst_count_d = burst_count_q;
    err_beat_d    = err_beat_q;
    trunc_d       = trunc_q;
    fcs_d         = fcs_q;
    lock_d        = lock_q;
    ldl_d         = ldl_q;
    fin_c         = 1'b0;
    fin_trunc_c   = 1'b0;
    fin_err_c     = 1'b0;

    if (rx_axis_tvalid && rx_axis_tlast && rx_axis_tuser) fcs_d = sat_inc16(fcs_q);

    case (state_q)
      ST_PRE: begin
        if (rx_axis_tvalid) begin
          if (is_sync_c) begin
            pcnt_d = sat_inc(pcnt_q);
          end else if (pcnt_q >= pre_eff_c) begin
            exp_d = prbs_next(rx_axis_tdata);
            if (burst_eff_c == DW'(1)) begin
              fin_c = 1'b1;
            end else begin
              state_d = ST_CHECK;
              bcnt_d  = DW'(1);
              gap_d   = '0;
              berr_d  = 1'b0;
            end
          end else begin
            state_d = ST_HUNT;
          end
        end
      end
      ST_CHECK: begin
        if (rx_axis_tvalid) begin
          bcnt_d = sat_inc(bcnt_q);
          gap_d  = '0;
          exp_d  = prbs_next(rx_axis_tdata);
          if (mism_c) begin
            err_beat_d = sat_inc(err_beat_q);
            berr_d     = 1'b1;
          end
          if (bcnt_d >= burst_eff_c) begin
            fin_c     = 1'b1;
            fin_err_c = berr_q | mism_c;
          end else if (rx_axis_tlast) begin
            fin_c       = 1'b1;
            fin_trunc_c = 1'b1;
            fin_err_c   = berr_q | mism_c;
          end
        end else begin
          gap_d = gap_q + DW'(1);
          if (gap_d >= DW'(GAP_TIMEOUT)) begin
            fin_c       = 1'b1;
            fin_trunc_c = 1'b1;
            fin_err_c   = berr_q;
          end
        end
      end
      default: begin
        // HUNT, and DONE which evaluates its beat as HUNT input.
        state_d = ST_HUNT;
        if (rx_axis_tvalid && is_sync_c) begin
          state_d = ST_PRE;
          pcnt_d  = DW'(1);
        end
      end
    endcase

    if (fin_c) begin
      state_d       = ST_DONE;
      burst_done_d  = 1'b1;
      burst_count_d = sat_inc(burst_count_q);
      if (fin_trunc_c) trunc_d = sat_inc(trunc_q);
      if (!fin_trunc_c && !fin_err_c) begin
        clean_d = sat_inc(clean_q);
        if (clean_d >= DW'(LOCK_BURSTS)) lock_d = 1'b1;
      end else begin
        clean_d = '0;
        lock_d  = 1'b0;
      end
    end

    if (lock_q && !lock_d) ldl_d = 1'b1;
    if (link_down_latched_reset_in) ldl_d = 1'b0;
  end

  // State and statistics registers.
  always_ff @(posedge rx_axis_usrclk) begin
    if (reset_in) begin
      state_q       <= ST_HUNT;
      pcnt_q        <= '0;
      bcnt_q        <= '0;
      gap_q         <= '0;
      exp_q         <= '0;
      berr_q        <= 1'b0;
      clean_q       <= '0;
      burst_done_q  <= 1'b0;
      burst_count_q <= '0;
      err_beat_q    <= '0;
      trunc_q       <= '0;
      fcs_q         <= '0;
      lock_q        <= 1'b0;
      ldl_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pcnt_q        <= pcnt_d;
      bcnt_q        <= bcnt_d;
      gap_q         <= gap_d;
      exp_q         <= exp_d;
      berr_q        <= berr_d;
      clean_q       <= clean_d;
      burst_done_q  <= burst_done_d;
      burst_count_q <= burst_count_d;
      err_beat_q    <= err_beat_d;
      trunc_q       <= trunc_d;
      fcs_q         <= fcs_d;
      lock_q        <= lock_d;
      ldl_q         <= ldl_d;
    end
  end

`ifdef PRBS_BIT_ERR_CNT_EN
  logic [DW-1:0] bit_err_q, bit_err_d;
  logic [5:0]    pop_c;
  logic [DW:0]   bit_sum_c;

  // Saturating accumulation of mismatched payload bits.
  always_comb begin
    pop_c = '0;
    for (int unsigned i = 0; i < DW; i++) pop_c = pop_c + 6'(diff_c[i]);
    bit_sum_c = {1'b0, bit_err_q} + (DW+1)'(pop_c);
    bit_err_d = bit_err_q;
    if (mism_c) bit_err_d = bit_sum_c[DW] ? '1 : bit_sum_c[DW-1:0];
  end

  // Bit error counter register.
  always_ff @(posedge rx_axis_usrclk) begin
    if (reset_in) bit_err_q <= '0;
    else          bit_err_q <= bit_err_d;
  end

  assign bit_err_count = bit_err_q;
`else
  assign bit_err_count = '0;
`endif

  assign burst_done        = burst_done_q;
  assign burst_count       = burst_count_q;
  assign err_beat_count    = err_beat_q;
  assign trunc_count       = trunc_q;
  assign fcs_err_count     = fcs_q;
  assign lock              = lock_q;
  assign link_down_latched = ldl_q;

endmodule

// File: tb/tb_prbs_burst_checker.sv
// Self-checking bench for prbs_burst_checker: a table of directed bursts
// with fixed expectations, a few hand-written sequences, then random bursts
// compared against a transaction-level model.
`timescale 1ns/1ps
module tb_prbs_burst_checker;

  localparam logic [31:0] SYNC  = 32'h05560556;
  localparam int          GAP   = 64;
  localparam int          LOCKN = 4;
`ifdef PRBS_BIT_ERR_CNT_EN
  localparam bit BITS_EN = 1'b1;
`else
  localparam bit BITS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_in;
  logic [31:0] tdata;
  logic        tvalid, tlast, tuser;
  logic [31:0] preamble_length, burst_length;
  logic        ldl_rst;
  logic        burst_done;
  logic [31:0] burst_count, err_beat_count, bit_err_count, trunc_count;
  logic [15:0] fcs_err_count;
  logic        lock, link_down_latched;

  always #5 clk = ~clk;

  prbs_burst_checker #(.SYNC_WORD(SYNC), .GAP_TIMEOUT(GAP), .LOCK_BURSTS(LOCKN)) dut (
    .rx_axis_usrclk             (clk),
    .reset_in                   (reset_in),
    .rx_axis_tdata              (tdata),
    .rx_axis_tvalid             (tvalid),
    .rx_axis_tlast              (tlast),
    .rx_axis_tuser              (tuser),
    .preamble_length            (preamble_length),
    .burst_length               (burst_length),
    .link_down_latched_reset_in (ldl_rst),
    .burst_done                 (burst_done),
    .burst_count                (burst_count),
    .err_beat_count             (err_beat_count),
    .bit_err_count              (bit_err_count),
    .trunc_count                (trunc_count),
    .fcs_err_count              (fcs_err_count),
    .lock                       (lock),
    .link_down_latched          (link_down_latched)
  );

  typedef struct {
    int          np;
    int unsigned pre_len;
    int unsigned burst_len;
    int          flip_beat;
    logic [31:0] flip_mask;
    int          trunc_at;
    int          gap_at;
    int          gap_len;
    bit          end_last;
    bit          tuser;
    int          tail;
    int          exp_done;
    int          exp_err;
    int          exp_bits;
    int          exp_trunc;
    int          exp_fcs;
    bit          exp_lock;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  int m_done_exp = 0;
  int m_bursts, m_err, m_bits, m_trunc, m_fcs, m_clean;
  bit m_lock, m_ldl;

  // Count burst_done pulses, sampled away from the active edge.
  always @(negedge clk) if (burst_done === 1'b1) done_seen <= done_seen + 1;

  // Stream view of the PRBS rule: append 32 new bits after the given word.
  function automatic logic [31:0] prbs_next(input logic [31:0] w);
    bit q[$];
    logic [31:0] r;
    for (int i = 31; i >= 0; i--) q.push_back(w[i]);
    for (int i = 0; i < 32; i++) q.push_back(q[q.size()-31] ^ q[q.size()-28]);
    for (int i = 0; i < 32; i++) r[31-i] = q[32+i];
    return r;
  endfunction

  function automatic vec_t mk(input int np, input int unsigned pl, input int unsigned bl,
                              input int fb, input logic [31:0] fm, input int tr,
                              input int ga, input int gl, input bit el, input bit tu,
                              input int tl, input int ed, input int ee, input int eb,
                              input int et, input int ef, input bit elk);
    vec_t v;
    v.np = np; v.pre_len = pl; v.burst_len = bl; v.flip_beat = fb; v.flip_mask = fm;
    v.trunc_at = tr; v.gap_at = ga; v.gap_len = gl; v.end_last = el; v.tuser = tu;
    v.tail = tl; v.exp_done = ed; v.exp_err = ee; v.exp_bits = eb; v.exp_trunc = et;
    v.exp_fcs = ef; v.exp_lock = elk;
    return v;
  endfunction

  task automatic chk(input string tag, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d, expected %0d", tag, name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic l, input logic u);
    tvalid = v; tdata = d; tlast = l; tuser = u;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic model_reset();
    m_bursts = 0; m_err = 0; m_bits = 0; m_trunc = 0; m_fcs = 0; m_clean = 0;
    m_lock = 1'b0; m_ldl = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk(tag, "burst_count", burst_count, m_bursts);
    chk(tag, "err_beat_count", err_beat_count, m_err);
    chk(tag, "bit_err_count", bit_err_count, BITS_EN ? m_bits : 0);
    chk(tag, "trunc_count", trunc_count, m_trunc);
    chk(tag, "fcs_err_count", 32'(fcs_err_count), m_fcs);
    chk(tag, "lock", 32'(lock), 32'(m_lock));
    chk(tag, "link_down_latched", 32'(link_down_latched), 32'(m_ldl));
    chk(tag, "burst_done_pulses", done_seen, m_done_exp);
  endtask

  // Drive one burst and fold its effect into the transaction model.
  task automatic send_burst(input vec_t b);
    logic [31:0] refw, d, expw;
    logic [31:0] rx[$];
    int  pre_eff, len, n_send, endb;
    bit  last_k, trunc_gap, trunc_t, dirty;
    preamble_length = b.pre_len;
    burst_length    = b.burst_len;
    pre_eff = (b.pre_len == 0) ? 1 : int'(b.pre_len);
    len     = (b.burst_len == 0) ? 1 : int'(b.burst_len);
    n_send  = (b.trunc_at > 0) ? b.trunc_at : len;
    for (int i = 0; i < b.np; i++) step(1'b1, SYNC, 1'b0, 1'b0);
    refw = $urandom;
    if (refw == SYNC) refw = ~refw;
    for (int k = 1; k <= n_send; k++) begin
      if (k == b.gap_at && b.gap_len > 0) idle(b.gap_len);
      d = refw ^ ((k == b.flip_beat) ? b.flip_mask : 32'h0);
      last_k = (b.trunc_at > 0) ? (k == b.trunc_at) : (b.end_last && k == len);
      step(1'b1, d, last_k, b.tuser);
      if (last_k && b.tuser) m_fcs++;
      rx.push_back(d);
      refw = prbs_next(refw);
    end
    idle(b.tail);
    if (b.np >= pre_eff) begin
      m_bursts++;
      m_done_exp++;
      trunc_gap = (len >= 2) && (b.gap_at >= 2) && (b.gap_at <= n_send) && (b.gap_len >= GAP);
      trunc_t   = !trunc_gap && (b.trunc_at > 0);
      endb      = trunc_gap ? b.gap_at - 1 : n_send;
      dirty     = trunc_gap || trunc_t;
      for (int k = 2; k <= endb; k++) begin
        expw = prbs_next(rx[k-2]);
        if (rx[k-1] != expw) begin
          m_err++;
          m_bits += $countones(rx[k-1] ^ expw);
          dirty = 1'b1;
        end
      end
      if (trunc_gap || trunc_t) m_trunc++;
      if (!dirty) begin
        m_clean++;
        if (m_clean >= LOCKN) m_lock = 1'b1;
      end else begin
        if (m_lock) m_ldl = 1'b1;
        m_clean = 0;
        m_lock  = 1'b0;
      end
    end
  endtask

  vec_t tbl[11];
  vec_t v;
  int tab_done, tab_err, tab_bits, tab_trunc, tab_fcs, len_r;
  logic [31:0] w;

  initial begin
    // np pre bl  flip mask  trunc gap_at gap_len end_last tuser tail | done err bits trunc fcs lock
    tbl[0]  = mk(4, 4, 16, 0, 32'h0,        0,  0,  0, 1'b1, 1'b0, 2, 1, 0, 0, 0, 0, 1'b0);
    tbl[1]  = mk(4, 4, 16, 8, 32'h1,        0,  0,  0, 1'b1, 1'b0, 2, 1, 2, 3, 0, 0, 1'b0);
    tbl[2]  = mk(3, 4, 16, 0, 32'h0,        0,  0,  0, 1'b1, 1'b0, 2, 0, 0, 0, 0, 0, 1'b0);
    tbl[3]  = mk(4, 4, 16, 0, 32'h0,       10,  0,  0, 1'b0, 1'b1, 2, 1, 0, 0, 1, 1, 1'b0);
    tbl[4]  = mk(4, 4, 16, 0, 32'h0,        0,  6, 64, 1'b1, 1'b0, 2, 1, 0, 0, 1, 0, 1'b0);
    tbl[5]  = mk(4, 4, 16, 0, 32'h0,        0,  6, 63, 1'b1, 1'b1, 2, 1, 0, 0, 0, 1, 1'b0);
    tbl[6]  = mk(4, 4,  1, 0, 32'h0,        0,  0,  0, 1'b1, 1'b0, 2, 1, 0, 0, 0, 0, 1'b0);
    tbl[7]  = mk(1, 0,  3, 0, 32'h0,        0,  0,  0, 1'b0, 1'b0, 2, 1, 0, 0, 0, 0, 1'b0);
    tbl[8]  = mk(4, 4, 16, 0, 32'h0,        0,  0,  0, 1'b1, 1'b0, 0, 1, 0, 0, 0, 0, 1'b1);
    tbl[9]  = mk(5, 4, 16, 0, 32'h0,        0,  0,  0, 1'b1, 1'b0, 2, 1, 0, 0, 0, 0, 1'b1);
    tbl[10] = mk(4, 4, 16, 3, 32'h00010000, 0,  0,  0, 1'b1, 1'b0, 2, 1, 2, 3, 0, 0, 1'b0);

    reset_in = 1'b1; ldl_rst = 1'b0; preamble_length = 32'd4; burst_length = 32'd16;
    tvalid = 1'b0; tdata = '0; tlast = 1'b0; tuser = 1'b0;
    model_reset();
    idle(2);
    reset_in = 1'b0;
    idle(1);
    check_all("reset");

    tab_done = 0; tab_err = 0; tab_bits = 0; tab_trunc = 0; tab_fcs = 0;
    for (int i = 0; i < 11; i++) begin
      send_burst(tbl[i]);
      tab_done  += tbl[i].exp_done;
      tab_err   += tbl[i].exp_err;
      tab_bits  += tbl[i].exp_bits;
      tab_trunc += tbl[i].exp_trunc;
      tab_fcs   += tbl[i].exp_fcs;
      if (tbl[i].tail > 0) begin
        chk($sformatf("tbl%0d", i), "burst_count", burst_count, tab_done);
        chk($sformatf("tbl%0d", i), "err_beat_count", err_beat_count, tab_err);
        chk($sformatf("tbl%0d", i), "bit_err_count", bit_err_count, BITS_EN ? tab_bits : 0);
        chk($sformatf("tbl%0d", i), "trunc_count", trunc_count, tab_trunc);
        chk($sformatf("tbl%0d", i), "fcs_err_count", 32'(fcs_err_count), tab_fcs);
        chk($sformatf("tbl%0d", i), "lock", 32'(lock), 32'(tbl[i].exp_lock));
        check_all($sformatf("tbl%0d_model", i));
      end
    end
    chk("tbl_end", "link_down_latched", 32'(link_down_latched), 32'd1);

    // Clear the sticky loss-of-lock flag.
    ldl_rst = 1'b1;
    idle(1);
    ldl_rst = 1'b0;
    m_ldl = 1'b0;
    chk("ldl_clear", "link_down_latched", 32'(link_down_latched), 32'd0);

    // Lock up again, then reset in the middle of a burst.
    for (int i = 0; i < LOCKN; i++) begin
      send_burst(mk(4, 4, 8, 0, 32'h0, 0, 0, 0, 1'b1, 1'b0, 1, 0, 0, 0, 0, 0, 1'b0));
      check_all("relock");
    end
    chk("relock", "lock_up", 32'(lock), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, SYNC, 1'b0, 1'b0);
    w = $urandom;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, w ^ 32'h80, 1'b0, 1'b0);
      w = prbs_next(w);
    end
    reset_in = 1'b1;
    step(1'b1, w, 1'b1, 1'b1);
    reset_in = 1'b0;
    model_reset();
    check_all("midreset");
    idle(2);
    chk("midreset", "burst_done_pulses", done_seen, m_done_exp);
    send_burst(mk(4, 4, 16, 0, 32'h0, 0, 0, 0, 1'b1, 1'b0, 2, 0, 0, 0, 0, 0, 1'b0));
    chk("post_reset", "burst_count_is_1", burst_count, 32'd1);
    check_all("post_reset");

    // Random bursts against the transaction model.
    for (int r = 0; r < 30; r++) begin
      v = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 1'b0, 1'b0, 1, 0, 0, 0, 0, 0, 1'b0);
      v.pre_len   = $urandom_range(0, 4);
      v.np        = $urandom_range(1, 5);
      v.burst_len = $urandom_range(0, 12);
      len_r = (v.burst_len == 0) ? 1 : int'(v.burst_len);
      if ($urandom_range(0, 2) == 0) begin
        v.flip_beat = $urandom_range(1, len_r);
        v.flip_mask = $urandom | (32'h1 << $urandom_range(0, 31));
      end
      if (len_r >= 3 && $urandom_range(0, 3) == 0) v.trunc_at = $urandom_range(2, len_r - 1);
      if (len_r >= 2 && $urandom_range(0, 3) == 0) begin
        v.gap_at  = $urandom_range(2, len_r);
        v.gap_len = ($urandom_range(0, 1) == 1) ? $urandom_range(60, 68) : $urandom_range(1, 5);
      end
      v.end_last = 1'($urandom_range(0, 1));
      v.tuser    = 1'($urandom_range(0, 1));
      v.tail     = $urandom_range(1, 3);
      send_burst(v);
      check_all($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
